// File: rtl/hazard_if.sv
// Interface that groups the stage-register fields the hazard unit reads and the interlock controls it returns.
// The pipeline side uses the master modport and the hazard unit uses the slave modport.
interface hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_ID_Rs;
    logic [4:0]       IF_ID_Rt;
    logic             ID_UsesRt;
    logic             ID_Branch;
    logic             ID_MulDiv;
    logic             ID_ReadsHiLo;
    logic [4:0]       ID_EX_Rt;
    logic             ID_EX_MemRead;
    logic [4:0]       EX_MEM_Rd;
    logic             EX_MEM_MemRead;
    logic             BranchTaken;
    logic             Jump;
    logic             PC_Write;
    logic             IF_ID_Write;
    logic             ID_EX_Bubble;
    logic             IF_ID_Flush;
    logic             MD_Busy;
    logic [CNT_W-1:0] StallCycles;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output IF_ID_Rs, IF_ID_Rt, ID_UsesRt, ID_Branch, ID_MulDiv, ID_ReadsHiLo,
               ID_EX_Rt, ID_EX_MemRead, EX_MEM_Rd, EX_MEM_MemRead, BranchTaken, Jump,
        input  PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MD_Busy,
               StallCycles, FlushCount
    );

    modport slave (
        input  IF_ID_Rs, IF_ID_Rt, ID_UsesRt, ID_Branch, ID_MulDiv, ID_ReadsHiLo,
               ID_EX_Rt, ID_EX_MemRead, EX_MEM_Rd, EX_MEM_MemRead, BranchTaken, Jump,
        output PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MD_Busy,
               StallCycles, FlushCount
    );
endinterface

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline, with a mult/div busy tracker.
// Define HAZARD_PERF_EN to build the saturating StallCycles/FlushCount counters.
module hazard_unit #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
) (
    input  logic    clk,
    input  logic    rst,
    hazard_if.slave hz
);
    localparam int MD_CNT_W = $clog2(MD_LATENCY + 1);

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_e;

    md_state_e           state_q, state_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    logic                lu_hz, bl_hz, md_hz, stall, flush, md_busy;

    assign lu_hz = hz.ID_EX_MemRead && (hz.ID_EX_Rt != 5'd0) &&
                   ((hz.ID_EX_Rt == hz.IF_ID_Rs) ||
                    (hz.ID_UsesRt && (hz.ID_EX_Rt == hz.IF_ID_Rt)));
    assign bl_hz = hz.ID_Branch && hz.EX_MEM_MemRead && (hz.EX_MEM_Rd != 5'd0) &&
                   ((hz.EX_MEM_Rd == hz.IF_ID_Rs) || (hz.EX_MEM_Rd == hz.IF_ID_Rt));
    assign md_hz = md_busy && (hz.ID_MulDiv || hz.ID_ReadsHiLo);
    assign stall = lu_hz || bl_hz || md_hz;
    // A stalled control transfer is held in ID and flushes once the stall clears.
    assign flush = !stall && ((hz.BranchTaken && hz.ID_Branch) || hz.Jump);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MD_IDLE: begin
                if (hz.ID_MulDiv && !stall) begin
                    state_d = MD_BUSY;
                    cnt_d   = MD_CNT_W'(MD_LATENCY - 1);
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        md_busy         = (state_q == MD_BUSY);
        hz.MD_Busy      = md_busy;
        hz.PC_Write     = !stall;
        hz.IF_ID_Write  = !stall;
        hz.ID_EX_Bubble = stall;
        hz.IF_ID_Flush  = flush;
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.StallCycles = stall_cnt_q;
    assign hz.FlushCount  = flush_cnt_q;
`else
    assign hz.StallCycles = '0;
    assign hz.FlushCount  = '0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit with MD_LATENCY=4 and CNT_W=4: directed vectors push
// hand-computed expectations, a negedge monitor pops and compares them.
module tb_hazard_unit;
    localparam int CW = 4;

    typedef struct {
        string        name;
        logic         stall;
        logic         flush;
        logic         busy;
        logic [CW-1:0] stall_cnt;
        logic [CW-1:0] flush_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [CW-1:0] m_stall = '0;
    logic [CW-1:0] m_flush = '0;

    hazard_if #(.CNT_W(CW)) hz ();

    hazard_unit #(.MD_LATENCY(4), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One cycle of stimulus: inputs change 1 time unit after the edge, expectation is queued.
    task automatic cyc(input string name, input logic r,
                       input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                       input logic br, input logic md, input logic hilo,
                       input logic [4:0] ex_rt, input logic ex_mr,
                       input logic [4:0] mem_rd, input logic mem_mr,
                       input logic taken, input logic jump,
                       input logic e_stall, input logic e_flush, input logic e_busy);
        exp_t e;
        @(posedge clk);
        #1;
        rst               = r;
        hz.IF_ID_Rs       = rs;
        hz.IF_ID_Rt       = rt;
        hz.ID_UsesRt      = uses_rt;
        hz.ID_Branch      = br;
        hz.ID_MulDiv      = md;
        hz.ID_ReadsHiLo   = hilo;
        hz.ID_EX_Rt       = ex_rt;
        hz.ID_EX_MemRead  = ex_mr;
        hz.EX_MEM_Rd      = mem_rd;
        hz.EX_MEM_MemRead = mem_mr;
        hz.BranchTaken    = taken;
        hz.Jump           = jump;
        e.name  = name;
        e.stall = e_stall;
        e.flush = e_flush;
        e.busy  = e_busy;
`ifdef HAZARD_PERF_EN
        e.stall_cnt = m_stall;
        e.flush_cnt = m_flush;
`else
        e.stall_cnt = '0;
        e.flush_cnt = '0;
`endif
        sb.push_back(e);
        if (r) begin
            m_stall = '0;
            m_flush = '0;
        end else begin
            if (e_stall && m_stall != '1) m_stall = m_stall + 1'b1;
            if (e_flush && m_flush != '1) m_flush = m_flush + 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".pc_write"},    16'(hz.PC_Write),     16'(!e.stall));
            check({e.name, ".if_id_write"}, 16'(hz.IF_ID_Write),  16'(!e.stall));
            check({e.name, ".bubble"},      16'(hz.ID_EX_Bubble), 16'(e.stall));
            check({e.name, ".flush"},       16'(hz.IF_ID_Flush),  16'(e.flush));
            check({e.name, ".md_busy"},     16'(hz.MD_Busy),      16'(e.busy));
            check({e.name, ".stall_cnt"},   16'(hz.StallCycles),  16'(e.stall_cnt));
            check({e.name, ".flush_cnt"},   16'(hz.FlushCount),   16'(e.flush_cnt));
        end
    end

    initial begin
        hz.IF_ID_Rs = '0; hz.IF_ID_Rt = '0; hz.ID_UsesRt = 1'b0; hz.ID_Branch = 1'b0;
        hz.ID_MulDiv = 1'b0; hz.ID_ReadsHiLo = 1'b0; hz.ID_EX_Rt = '0; hz.ID_EX_MemRead = 1'b0;
        hz.EX_MEM_Rd = '0; hz.EX_MEM_MemRead = 1'b0; hz.BranchTaken = 1'b0; hz.Jump = 1'b0;
        @(posedge clk);
        //  name          rst rs rt ur br md hl exrt exmr memrd memmr tk jp   stall flush busy
        cyc("reset_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
        cyc("lu_rs",       0, 2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0,  1, 0, 0);
        cyc("lu_r0",       0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0);
        cyc("lu_nomatch",  0, 3, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0,  0, 0, 0);
        cyc("ldbr_lu",     0, 3, 0, 0, 1, 0, 0, 3, 1, 0, 0, 1, 0,  1, 0, 0);
        cyc("ldbr_bl",     0, 3, 0, 0, 1, 0, 0, 0, 0, 3, 1, 1, 0,  1, 0, 0);
        cyc("ldbr_go",     0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 0);
        cyc("br_nt",       0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
        cyc("bl_rt",       0, 0, 5, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0,  1, 0, 0);
        cyc("bl_r0",       0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0,  0, 1, 0);
        cyc("bl_nobr",     0, 5, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0,  0, 0, 0);
        cyc("jump",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0);
        cyc("jump_lu",     0, 7, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1,  1, 0, 0);
        cyc("rt_nouse",    0, 0, 4, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0,  0, 0, 0);
        cyc("rt_use",      0, 0, 4, 1, 0, 0, 0, 4, 1, 0, 0, 0, 0,  1, 0, 0);
        cyc("mult",        0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
        for (int i = 0; i < 4; i++)
            cyc("mflo_wait", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1);
        cyc("mflo_go",     0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0);
        cyc("mult_a",      0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
        for (int i = 0; i < 4; i++)
            cyc("mult_b_wait", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1);
        cyc("mult_b_go",   0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
        cyc("rst_busy1",   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1);
        cyc("rst_busy2",   1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1);
        cyc("after_rst",   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0);
        cyc("md_lu",       0, 2, 0, 0, 0, 1, 0, 2, 1, 0, 0, 0, 0,  1, 0, 0);
        cyc("md_go",       0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
        for (int i = 0; i < 4; i++)
            cyc("md_drain",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1);
        cyc("md_done",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
        for (int i = 0; i < 20; i++)
            cyc("sat_stall", 0, 9, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0,  1, 0, 0);
        cyc("final_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Pipeline interlock controller for the 5-stage MIPS core; the stalling and flushing side that complements operand forwarding.
- Detects hazards forwarding cannot cover: load-use in EX, load feeding a branch resolved in ID, and HI/LO or mult/div conflicts with the multi-cycle multiply/divide unit.
- Drives PC/IF_ID write enables, inserts ID_EX bubbles and flushes IF_ID on taken control transfers.
- Sits beside the forwarding logic and consumes the same stage register fields.

Parameters:
MD_LATENCY, 32, cycles the mult/div unit stays busy after issue (legal range 2..63).
CNT_W, 16, width of optional performance counters.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
IF_ID_Rs  in  5  rs of instruction in ID
IF_ID_Rt  in  5  rt of instruction in ID
ID_UsesRt  in  1  ID instruction reads rt as a source
ID_Branch  in  1  ID instruction is a branch compared in ID
ID_MulDiv  in  1  ID instruction is mult/multu/div/divu
ID_ReadsHiLo  in  1  ID instruction is mfhi/mflo/mthi/mtlo
ID_EX_Rt  in  5  load destination of EX instruction
ID_EX_MemRead  in  1  EX instruction is a load
EX_MEM_Rd  in  5  destination of MEM instruction
EX_MEM_MemRead  in  1  MEM instruction is a load
BranchTaken  in  1  branch in ID resolved taken
Jump  in  1  ID instruction is j/jal/jr/jalr
PC_Write  out  1  PC update enable
IF_ID_Write  out  1  IF_ID register enable
ID_EX_Bubble  out  1  load NOP control into ID_EX
IF_ID_Flush  out  1  clear IF_ID at next edge
MD_Busy  out  1  mult/div unit busy
StallCycles  out  CNT_W  stall cycle count (optional feature)
FlushCount  out  CNT_W  flush count (optional feature)

Behaviour:
- Register 0 never causes a hazard; all register matches require a nonzero register.
- Combinational hazard terms:
  - LU: ID_EX_MemRead, ID_EX_Rt matches IF_ID_Rs, or matches IF_ID_Rt with ID_UsesRt.
  - BL: ID_Branch, EX_MEM_MemRead, EX_MEM_Rd matches IF_ID_Rs or IF_ID_Rt.
  - MD: MD_Busy, and either ID_MulDiv or ID_ReadsHiLo.
- stall = LU | BL | MD. A branch after a load therefore stalls exactly 2 cycles: LU, then BL.
- When stalled: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0. The stalled control transfer is ignored until the stall clears.
- When not stalled: PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=(BranchTaken&ID_Branch)|Jump.
- All above outputs are combinational and valid the same cycle.
- Mult/div FSM, registered:
  - States: IDLE, BUSY. Counter width is ceil(log2(MD_LATENCY+1)).
  - IDLE→BUSY when ID_MulDiv & !stall; counter loads MD_LATENCY-1.
  - BUSY: counter decrements each cycle; BUSY→IDLE when counter==0.
  - MD_Busy=1 in BUSY. First issue yields exactly MD_LATENCY busy cycles.
  - A second mult/div is stalled in ID during BUSY and issues on the first IDLE cycle. Issue in IDLE sets no back-to-back overlap.
- Reset (synchronous, priority over everything): FSM=IDLE, counter=0, MD_Busy=0, counters=0. Combinational outputs follow from the reset state: PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0 unless inputs assert hazards.
- Reset mid-BUSY returns to IDLE on that edge; the next cycle is not busy.
- Simultaneous LU and taken branch: stall wins; the flush occurs on the later non-stalled cycle.

Optional Feature:
Macro HAZARD_PERF_EN.
- Defined: StallCycles increments each cycle stall=1; FlushCount increments each cycle IF_ID_Flush=1. Both saturate at all-ones and clear on rst.
- Undefined: no counter registers; both outputs are constant 0.

Test Plan:
1. lw $2 in EX (ID_EX_MemRead=1, ID_EX_Rt=2); ID reads Rs=2 → PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 for 1 cycle. Same stimulus with Rt=0 and Rs=0 → no stall.
2. lw $3 followed by beq $3 → cycle1 LU stall, cycle2 BL stall (EX_MEM_Rd=3), cycle3 resolves with BranchTaken=1 → IF_ID_Flush=1; 2 bubbles total.
3. Load-use on rt with ID_UsesRt=0 (e.g. addi writing rt) → no stall. With ID_UsesRt=1 → 1-cycle stall.
4. MD_LATENCY=4: mult issues, then mflo in ID → MD_Busy high 4 cycles, mflo stalled 4 cycles, issues cycle 5. Back-to-back mult stalls identically.
5. rst asserted on the 2nd BUSY cycle → next cycle MD_Busy=0, a pending mflo proceeds, counters read 0.
6. HAZARD_PERF_EN defined, CNT_W=4: 20 stall cycles → StallCycles=15 (saturated). Macro undefined → StallCycles=0 throughout.
